mem_access_ctrl: RTL and testbench

- MEM-stage consumer of the EX/MEM pipeline register outputs.
- Takes the registered ALU result, control bits and store data, and performs the data-memory access over a req/ack handshake.
- Aligns load data and generates store byte-enables.
- Stalls upstream while an access is outstanding, then presents a registered result to the MEM/WB stage.

---
 rtl/mem_access_ctrl.sv | 200 ++++++++++++++++++++
 tb/tb_mem_access_ctrl.sv | 325 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_access_ctrl.sv
// MEM-stage data-memory access controller: issues aligned req/ack accesses,
// builds store byte-enables, aligns load data and registers the MEM/WB result.
module mem_access_ctrl #(
  parameter int unsigned TIMEOUT = 16
) (
  input  logic        clk,
  input  logic        Reset,
  input  logic        Valid_in,
  input  logic [31:0] ALUShift_out_in,
  input  logic [31:0] StoreData_in,
  input  logic        MemWr_in,
  input  logic        MemtoReg_in,
  input  logic [1:0]  LoadType_in,
  input  logic        LoadSign_in,
  input  logic        RegWr_in,
  input  logic        Exception_in,
  input  logic [4:0]  Rd_in,
  output logic        Stall_out,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [3:0]  mem_be,
  output logic [31:0] mem_wdata,
  input  logic        mem_ack,
  input  logic [31:0] mem_rdata,
  output logic        Valid_out,
  output logic [31:0] WbData_out,
  output logic [4:0]  Rd_out,
  output logic        RegWr_out,
  output logic        Exception_out,
  output logic        AddrErr_out,
  output logic        BusErr_out
);

  localparam int unsigned CNT_W = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;

  typedef enum logic [0:0] {S_IDLE = 1'b0, S_WAIT = 1'b1} state_t;

  state_t           r_state;
  state_t           w_next;
  logic [CNT_W-1:0] r_cnt;
  logic [4:0]       r_rd;
  logic             r_regwr;
  logic [1:0]       r_lt;
  logic             r_sign;
  logic [1:0]       r_off;

  logic        w_half;
  logic        w_byte;
  logic        w_word;
  logic        w_memop;
  logic        w_misal;
  logic        w_ok;
  logic        w_last;
  logic [3:0]  w_be;
  logic [31:0] w_wdata;
  logic [7:0]  w_ld_byte;
  logic [15:0] w_ld_half;
  logic [31:0] w_load;

  // Access classification of the instruction sitting in EX/MEM
  assign w_half  = (LoadType_in == 2'b01);
  assign w_byte  = (LoadType_in == 2'b10);
  assign w_word  = ~(w_half | w_byte);
  assign w_memop = Valid_in & (MemWr_in | MemtoReg_in);
  assign w_misal = (w_half & ALUShift_out_in[0]) | (w_word & (|ALUShift_out_in[1:0]));
  assign w_ok    = w_memop & ~w_misal & ~Exception_in;
  assign w_last  = (r_cnt == CNT_W'(TIMEOUT - 1));

  // Store lane steering; loads drive no byte enables
  always_comb begin
    w_be    = 4'b0000;
    w_wdata = 32'h0;
    if (MemWr_in) begin
      if (w_byte) begin
        w_be    = 4'b0001 << ALUShift_out_in[1:0];
        w_wdata = {4{StoreData_in[7:0]}};
      end else if (w_half) begin
        w_be    = 4'b0011 << ALUShift_out_in[1:0];
        w_wdata = {2{StoreData_in[15:0]}};
      end else begin
        w_be    = 4'b1111;
        w_wdata = StoreData_in;
      end
    end
  end

  // Little-endian load extraction using the captured offset and size
  always_comb begin
    w_ld_byte = mem_rdata[{r_off, 3'b000} +: 8];
    w_ld_half = mem_rdata[{r_off[1], 4'b0000} +: 16];
    case (r_lt)
      2'b10:   w_load = {{24{r_sign & w_ld_byte[7]}}, w_ld_byte};
      2'b01:   w_load = {{16{r_sign & w_ld_half[15]}}, w_ld_half};
      default: w_load = mem_rdata;
    endcase
  end

  always_ff @(posedge clk or negedge Reset) begin
    if (!Reset) r_state <= S_IDLE;
    else        r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (w_ok) w_next = S_WAIT;
      S_WAIT:  if (mem_ack || w_last) w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  // Stall drops in the completion cycle so upstream advances on the retiring edge
  always_comb begin
    Stall_out = 1'b0;
    case (r_state)
      S_IDLE:  Stall_out = w_ok;
      S_WAIT:  Stall_out = ~mem_ack & ~w_last;
      default: Stall_out = 1'b0;
    endcase
  end

  always_ff @(posedge clk or negedge Reset) begin
    if (!Reset) begin
      mem_req       <= 1'b0;
      mem_we        <= 1'b0;
      mem_addr      <= 32'h0;
      mem_be        <= 4'h0;
      mem_wdata     <= 32'h0;
      Valid_out     <= 1'b0;
      WbData_out    <= 32'h0;
      Rd_out        <= 5'h0;
      RegWr_out     <= 1'b0;
      Exception_out <= 1'b0;
      AddrErr_out   <= 1'b0;
      BusErr_out    <= 1'b0;
      r_cnt         <= '0;
      r_rd          <= 5'h0;
      r_regwr       <= 1'b0;
      r_lt          <= 2'b00;
      r_sign        <= 1'b0;
      r_off         <= 2'b00;
    end else begin
      Valid_out   <= 1'b0;
      AddrErr_out <= 1'b0;
      BusErr_out  <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (w_ok) begin
            mem_req   <= 1'b1;
            mem_we    <= MemWr_in;
            mem_addr  <= {ALUShift_out_in[31:2], 2'b00};
            mem_be    <= w_be;
            mem_wdata <= w_wdata;
            r_rd      <= Rd_in;
            r_regwr   <= RegWr_in;
            r_lt      <= LoadType_in;
            r_sign    <= LoadSign_in;
            r_off     <= ALUShift_out_in[1:0];
            r_cnt     <= '0;
          end else if (Valid_in) begin
            Valid_out     <= 1'b1;
            WbData_out    <= ALUShift_out_in;
            Rd_out        <= Rd_in;
            Exception_out <= Exception_in;
            AddrErr_out   <= w_memop & w_misal & ~Exception_in;
            RegWr_out     <= RegWr_in & ~(w_memop & w_misal) & ~Exception_in;
          end
        end
        S_WAIT: begin
          r_cnt <= r_cnt + CNT_W'(1);
          // Ack takes priority over a coinciding timeout
          if (mem_ack) begin
            mem_req       <= 1'b0;
            Valid_out     <= 1'b1;
            Rd_out        <= r_rd;
            Exception_out <= 1'b0;
            if (mem_we) begin
              WbData_out <= {mem_addr[31:2], r_off};
              RegWr_out  <= 1'b0;
            end else begin
              WbData_out <= w_load;
              RegWr_out  <= r_regwr;
            end
          end else if (w_last) begin
            mem_req       <= 1'b0;
            Valid_out     <= 1'b1;
            BusErr_out    <= 1'b1;
            WbData_out    <= {mem_addr[31:2], r_off};
            Rd_out        <= r_rd;
            RegWr_out     <= 1'b0;
            Exception_out <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Scoreboard bench for mem_access_ctrl: stimulus pushes expected results,
// a memory responder checks requests and a monitor checks MEM/WB results.
module tb_mem_access_ctrl;

  localparam int TO = 4;

  logic        clk;
  logic        Reset;
  logic        Valid_in;
  logic [31:0] ALUShift_out_in;
  logic [31:0] StoreData_in;
  logic        MemWr_in;
  logic        MemtoReg_in;
  logic [1:0]  LoadType_in;
  logic        LoadSign_in;
  logic        RegWr_in;
  logic        Exception_in;
  logic [4:0]  Rd_in;
  logic        Stall_out;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [3:0]  mem_be;
  logic [31:0] mem_wdata;
  logic        mem_ack;
  logic [31:0] mem_rdata;
  logic        Valid_out;
  logic [31:0] WbData_out;
  logic [4:0]  Rd_out;
  logic        RegWr_out;
  logic        Exception_out;
  logic        AddrErr_out;
  logic        BusErr_out;

  logic r_ack;
  logic stray;
  logic resp_en;
  assign mem_ack = r_ack | stray;

  mem_access_ctrl #(.TIMEOUT(TO)) dut (
    .clk(clk), .Reset(Reset), .Valid_in(Valid_in),
    .ALUShift_out_in(ALUShift_out_in), .StoreData_in(StoreData_in),
    .MemWr_in(MemWr_in), .MemtoReg_in(MemtoReg_in), .LoadType_in(LoadType_in),
    .LoadSign_in(LoadSign_in), .RegWr_in(RegWr_in), .Exception_in(Exception_in),
    .Rd_in(Rd_in), .Stall_out(Stall_out), .mem_req(mem_req), .mem_we(mem_we),
    .mem_addr(mem_addr), .mem_be(mem_be), .mem_wdata(mem_wdata),
    .mem_ack(mem_ack), .mem_rdata(mem_rdata), .Valid_out(Valid_out),
    .WbData_out(WbData_out), .Rd_out(Rd_out), .RegWr_out(RegWr_out),
    .Exception_out(Exception_out), .AddrErr_out(AddrErr_out), .BusErr_out(BusErr_out)
  );

  typedef struct {
    logic [31:0] addr, sdata, rdata;
    logic        wr, ld, regwr, exc, sign;
    logic [1:0]  lt;
    logic [4:0]  rd;
    int          delay;
  } instr_t;

  typedef struct {
    logic [31:0] wb;
    logic [4:0]  rd;
    logic        regwr, exc, aerr, berr, chk_wb;
  } res_t;

  typedef struct {
    logic [31:0] addr, wdata, rdata;
    logic        we;
    logic [3:0]  be;
    int          delay;
  } req_t;

  res_t res_q[$];
  req_t req_q[$];
  int checks = 0;
  int errors = 0;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int size_of(input logic [1:0] lt);
    if (lt == 2'b10) return 1;
    if (lt == 2'b01) return 2;
    return 4;
  endfunction

  // Reference model: what the MEM stage should request and retire for one instruction
  function automatic void model(input instr_t in, output res_t r, output bit acc, output req_t q);
    int sz, off;
    bit memop, misal;
    logic [31:0] mask, v;
    sz    = size_of(in.lt);
    off   = int'(in.addr % 4);
    memop = in.wr || in.ld;
    misal = (in.addr % sz) != 0;
    r = '{wb: in.addr, rd: in.rd, regwr: 1'b0, exc: 1'b0, aerr: 1'b0, berr: 1'b0, chk_wb: 1'b1};
    q = '{addr: in.addr & 32'hFFFF_FFFC, wdata: 32'h0, rdata: in.rdata, we: in.wr, be: 4'h0, delay: in.delay};
    acc = memop && !misal && !in.exc;
    if (!acc) begin
      r.aerr  = memop && misal && !in.exc;
      r.exc   = in.exc;
      r.regwr = in.regwr && !r.aerr && !in.exc;
      return;
    end
    if (in.wr) begin
      q.be = 4'(((1 << sz) - 1) << off);
      for (int i = 0; i < 4; i++) q.wdata[8*i +: 8] = in.sdata[8*(i % sz) +: 8];
    end
    if (in.delay > TO - 1) begin
      r.berr   = 1'b1;
      r.chk_wb = 1'b0;
    end else if (in.wr) begin
      r.wb = in.addr;
    end else begin
      mask = (sz == 4) ? 32'hFFFF_FFFF : ((32'h1 << (8 * sz)) - 32'h1);
      v = (in.rdata >> (8 * off)) & mask;
      if (in.sign && v[8*sz-1]) v = v | ~mask;
      r.wb    = v;
      r.regwr = in.regwr;
    end
  endfunction

  function automatic instr_t mk(input bit wr, input bit ld, input logic [1:0] lt, input bit sign,
                                input logic [31:0] addr, input logic [31:0] sd, input logic [4:0] rd,
                                input bit regwr, input bit exc, input int delay, input logic [31:0] rdata);
    instr_t t;
    t = '{addr: addr, sdata: sd, rdata: rdata, wr: wr, ld: ld, regwr: regwr, exc: exc,
          sign: sign, lt: lt, rd: rd, delay: delay};
    return t;
  endfunction

  // Present one instruction and hold it while the stage stalls
  task automatic issue(input instr_t in);
    res_t r;
    req_t q;
    bit acc, st;
    int stalls, cyc, exp_st;
    model(in, r, acc, q);
    Valid_in        = 1'b1;
    ALUShift_out_in = in.addr;
    StoreData_in    = in.sdata;
    MemWr_in        = in.wr;
    MemtoReg_in     = in.ld;
    LoadType_in     = in.lt;
    LoadSign_in     = in.sign;
    RegWr_in        = in.regwr;
    Exception_in    = in.exc;
    Rd_in           = in.rd;
    if (acc) req_q.push_back(q);
    res_q.push_back(r);
    stalls = 0;
    cyc    = 0;
    forever begin
      #4;
      st = Stall_out;
      @(posedge clk);
      @(negedge clk);
      cyc++;
      if (!st) break;
      stalls++;
      if (cyc > 50) begin
        chk("stall_bound", 128'(cyc), 128'(0));
        break;
      end
    end
    exp_st = acc ? 1 + ((in.delay < TO - 1) ? in.delay : TO - 1) : 0;
    chk("stall_cycles", 128'(stalls), 128'(exp_st));
    Valid_in = 1'b0;
  endtask

  // Memory responder: checks the request, then acks after the chosen delay
  initial begin
    req_t q;
    int k;
    r_ack     = 1'b0;
    mem_rdata = 32'h0;
    forever begin
      @(negedge clk);
      if (resp_en && mem_req) begin
        if (req_q.size() == 0) begin
          chk("unexpected_req", 128'(mem_addr), 128'(0));
          @(negedge clk);
        end else begin
          q = req_q.pop_front();
          chk("req", {mem_addr, mem_we, mem_be, (mem_we ? mem_wdata : 32'h0)},
                     {q.addr, q.we, q.be, q.wdata});
          k = 0;
          while (1) begin
            if (k == q.delay) begin
              r_ack     = 1'b1;
              mem_rdata = q.rdata;
              @(negedge clk);
              r_ack     = 1'b0;
              mem_rdata = $urandom;
              break;
            end
            if (k == TO - 1) begin
              @(negedge clk);
              break;
            end
            mem_rdata = $urandom;
            @(negedge clk);
            if (!mem_req) begin
              chk("req_held", 128'(mem_req), 128'(1));
              break;
            end
            k++;
          end
          chk("req_drop", 128'(mem_req), 128'(0));
        end
      end
    end
  end

  // Monitor: every valid result is compared with the oldest expectation
  initial begin
    res_t e;
    forever begin
      @(negedge clk);
      if (Valid_out) begin
        if (res_q.size() == 0) begin
          chk("unexpected_valid", 128'(WbData_out), 128'(0));
        end else begin
          e = res_q.pop_front();
          chk("result",
              {(e.chk_wb ? WbData_out : 32'h0), Rd_out, RegWr_out, Exception_out, AddrErr_out, BusErr_out},
              {(e.chk_wb ? e.wb : 32'h0), e.rd, e.regwr, e.exc, e.aerr, e.berr});
        end
      end
    end
  end

  function automatic logic [127:0] all_outs();
    return 128'({mem_req, mem_we, mem_addr, mem_be, mem_wdata, Valid_out, WbData_out,
                 Rd_out, RegWr_out, Exception_out, AddrErr_out, BusErr_out, Stall_out});
  endfunction

  initial begin
    #2_000_000;
    $display("FAIL watchdog expired at %0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    instr_t t;
    logic [31:0] a;
    logic [1:0] lt;
    int op;
    Reset = 1'b0; stray = 1'b0; resp_en = 1'b1;
    Valid_in = 1'b0; ALUShift_out_in = 32'h0; StoreData_in = 32'h0;
    MemWr_in = 1'b0; MemtoReg_in = 1'b0; LoadType_in = 2'b00; LoadSign_in = 1'b0;
    RegWr_in = 1'b0; Exception_in = 1'b0; Rd_in = 5'h0;
    #12;
    chk("reset_outputs", all_outs(), 128'(0));
    @(negedge clk);
    Reset = 1'b1;
    @(negedge clk);

    issue(mk(0, 0, 2'b00, 0, 32'h1234, 32'h0, 5'd5, 1, 0, 0, 32'h0));
    issue(mk(0, 1, 2'b10, 1, 32'h103, 32'h0, 5'd6, 1, 0, 2, 32'h80FF_0000));
    issue(mk(1, 0, 2'b01, 0, 32'h202, 32'hAAAA_BEEF, 5'd7, 1, 0, 1, 32'h0));
    issue(mk(0, 1, 2'b00, 0, 32'h101, 32'h0, 5'd8, 1, 0, 0, 32'h0));
    issue(mk(1, 0, 2'b00, 0, 32'h300, 32'h1111_2222, 5'd9, 1, 1, 0, 32'h0));
    issue(mk(0, 1, 2'b00, 0, 32'h400, 32'h0, 5'd10, 1, 0, 10, 32'h0));
    issue(mk(0, 1, 2'b00, 0, 32'h404, 32'h0, 5'd11, 1, 0, TO - 1, 32'hCAFE_F00D));
    issue(mk(0, 1, 2'b01, 0, 32'h406, 32'h0, 5'd12, 1, 0, 0, 32'h9876_5432));

    // Reset in the middle of an outstanding access
    resp_en         = 1'b0;
    Valid_in        = 1'b1;
    ALUShift_out_in = 32'h500;
    MemWr_in        = 1'b0;
    MemtoReg_in     = 1'b1;
    LoadType_in     = 2'b00;
    Exception_in    = 1'b0;
    RegWr_in        = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk("wait_req", 128'(mem_req), 128'(1));
    @(negedge clk);
    #2;
    Reset    = 1'b0;
    Valid_in = 1'b0;
    #1;
    chk("mid_wait_reset", all_outs(), 128'(0));
    @(negedge clk);
    Reset   = 1'b1;
    resp_en = 1'b1;
    @(negedge clk);
    issue(mk(0, 1, 2'b00, 0, 32'h600, 32'h0, 5'd13, 1, 0, 1, 32'h1357_9BDF));
    stray = 1'b1;
    @(negedge clk);
    stray = 1'b0;
    chk("stray_ack", {Valid_out, mem_req, BusErr_out}, 3'b000);
    @(negedge clk);
    issue(mk(1, 0, 2'b10, 0, 32'h703, 32'h0000_005A, 5'd14, 1, 0, 0, 32'h0));

    for (int n = 0; n < 200; n++) begin
      op = $urandom_range(0, 2);
      lt = 2'($urandom_range(0, 3));
      a  = $urandom;
      if ($urandom_range(0, 3) != 0) a = a & ~32'(size_of(lt) - 1);
      t = mk(op == 2, op == 1, lt, 1'($urandom), a, $urandom, 5'($urandom),
             1'($urandom), $urandom_range(0, 9) == 0, $urandom_range(0, TO + 1), $urandom);
      issue(t);
      if ($urandom_range(0, 3) == 0) @(negedge clk);
    end

    repeat (4) @(negedge clk);
    chk("queues_drained", 128'(res_q.size() + req_q.size()), 128'(0));
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
